// File: rtl/triangle_traversal_pkg.sv
// Shared types for the traversal block: fixed-point vertices, captured triangle,
// emitted pixel, bounding box and FSM states.
package triangle_traversal_pkg;

  typedef logic [31:0] q16_16_t;
  typedef logic [11:0] color12_t;

  typedef struct packed {
    q16_16_t x;
    q16_16_t y;
  } vertex_t;

  typedef struct packed {
    vertex_t  v0;
    vertex_t  v1;
    vertex_t  v2;
    color12_t c0;
    color12_t c1;
    color12_t c2;
    q16_16_t  z0;
    q16_16_t  z1;
    q16_16_t  z2;
  } triangle_state_t;

  typedef struct packed {
    triangle_state_t prim;
    logic [15:0]     x;
    logic [15:0]     y;
  } pixel_state_t;

  typedef struct packed {
    logic [15:0] xmin;
    logic [15:0] xmax;
    logic [15:0] ymin;
    logic [15:0] ymax;
  } bbox_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WALK  = 2'd2
  } trav_state_e;

  // Taking the top half of a two's-complement Q16.16 value is a floor, not a truncation.
  function automatic logic signed [15:0] int_part(input q16_16_t v);
    return $signed(v[31:16]);
  endfunction

endpackage

// File: rtl/triangle_traversal_if.sv
// Triangle-in / pixel-out stream bundle; slave is the traversal block, master the driver side.
interface triangle_traversal_if;
  import triangle_traversal_pkg::*;

  triangle_state_t in_triangle;
  logic            in_valid;
  logic            in_ready;
  logic            abort;
  pixel_state_t    out_pixel;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            tri_done;

  modport slave (
    input  in_triangle, in_valid, abort, out_ready,
    output in_ready, out_pixel, out_valid, busy, tri_done
  );

  modport master (
    output in_triangle, in_valid, abort, out_ready,
    input  in_ready, out_pixel, out_valid, busy, tri_done
  );

endinterface

// File: rtl/triangle_traversal_bbox_setup.sv
// Combinational bounding box of a triangle: floor each vertex, take min/max,
// detect a box fully off-screen, otherwise clamp it to the framebuffer.
module triangle_traversal_bbox_setup
  import triangle_traversal_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  triangle_state_t i_tri,
  output bbox_t           o_bbox,
  output logic            o_empty
);

  localparam logic signed [16:0] W_LIM = 17'(WIDTH);
  localparam logic signed [16:0] H_LIM = 17'(HEIGHT);

  function automatic logic signed [16:0] min3(input logic signed [16:0] a, b, c);
    logic signed [16:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [16:0] max3(input logic signed [16:0] a, b, c);
    logic signed [16:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  vertex_t            w_vtx [3];
  logic signed [16:0] w_ix  [3];
  logic signed [16:0] w_iy  [3];
  logic signed [16:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic               w_unused;

  assign w_vtx[0] = i_tri.v0;
  assign w_vtx[1] = i_tri.v1;
  assign w_vtx[2] = i_tri.v2;

  // 17 bits so a negative coordinate still compares correctly against WIDTH/HEIGHT.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_vtx
      assign w_ix[gi] = 17'(int_part(w_vtx[gi].x));
      assign w_iy[gi] = 17'(int_part(w_vtx[gi].y));
    end
  endgenerate

  assign w_xmin = min3(w_ix[0], w_ix[1], w_ix[2]);
  assign w_xmax = max3(w_ix[0], w_ix[1], w_ix[2]);
  assign w_ymin = min3(w_iy[0], w_iy[1], w_iy[2]);
  assign w_ymax = max3(w_iy[0], w_iy[1], w_iy[2]);

  always_comb begin
    o_empty = (w_xmax < 17'sd0) || (w_ymax < 17'sd0) ||
              (w_xmin >= W_LIM) || (w_ymin >= H_LIM);
    o_bbox.xmin = (w_xmin < 17'sd0) ? 16'd0 : w_xmin[15:0];
    o_bbox.ymin = (w_ymin < 17'sd0) ? 16'd0 : w_ymin[15:0];
    o_bbox.xmax = (w_xmax >= W_LIM) ? 16'(WIDTH - 1)  : w_xmax[15:0];
    o_bbox.ymax = (w_ymax >= H_LIM) ? 16'(HEIGHT - 1) : w_ymax[15:0];
  end

  // Fractions, colours and depths play no part in the box.
  assign w_unused = ^{i_tri.v0.x[15:0], i_tri.v0.y[15:0], i_tri.v1.x[15:0], i_tri.v1.y[15:0],
                      i_tri.v2.x[15:0], i_tri.v2.y[15:0], i_tri.c0, i_tri.c1, i_tri.c2,
                      i_tri.z0, i_tri.z1, i_tri.z2};

endmodule

// File: rtl/triangle_traversal.sv
// Accepts one triangle, computes its clamped bounding box and walks it in raster
// order (x fastest), emitting one candidate pixel per accepted beat.
module triangle_traversal
  import triangle_traversal_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic                clk,
  input  logic                rst,
  triangle_traversal_if.slave bus
);

  trav_state_e     r_state, w_state_next;
  triangle_state_t r_tri;
  logic [15:0]     r_x, r_y, r_xmin, r_xmax, r_ymax;
  logic            r_tri_done;
  bbox_t           w_bbox;
  logic            w_empty;
  logic            w_accept, w_beat, w_x_end, w_last;

  triangle_traversal_bbox_setup #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_bbox (
    .i_tri   (r_tri),
    .o_bbox  (w_bbox),
    .o_empty (w_empty)
  );

  assign w_accept = (r_state == IDLE) && bus.in_valid && !bus.abort;
  assign w_beat   = (r_state == WALK) && bus.out_ready;
  assign w_x_end  = (r_x >= r_xmax);
  assign w_last   = w_x_end && (r_y >= r_ymax);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_next = SETUP;
      SETUP:   w_state_next = w_empty ? IDLE : WALK;
      WALK:    if (w_beat && w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    // Flush wins over everything, including a same-cycle handshake.
    if (bus.abort) w_state_next = IDLE;
  end

  always_comb begin
    bus.in_ready       = (r_state == IDLE);
    bus.out_valid      = (r_state == WALK);
    bus.busy           = (r_state == SETUP) || (r_state == WALK);
    bus.tri_done       = r_tri_done;
    bus.out_pixel.prim = r_tri;
    bus.out_pixel.x    = r_x;
    bus.out_pixel.y    = r_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tri      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_xmin     <= '0;
      r_xmax     <= '0;
      r_ymax     <= '0;
      r_tri_done <= 1'b0;
    end else begin
      r_tri_done <= 1'b0;
      if (!bus.abort) begin
        if (w_accept) r_tri <= bus.in_triangle;
        if (r_state == SETUP) begin
          if (w_empty) begin
            r_tri_done <= 1'b1;
          end else begin
            r_x    <= w_bbox.xmin;
            r_y    <= w_bbox.ymin;
            r_xmin <= w_bbox.xmin;
            r_xmax <= w_bbox.xmax;
            r_ymax <= w_bbox.ymax;
          end
        end
        if (w_beat) begin
          if (!w_x_end) begin
            r_x <= r_x + 16'd1;
          end else if (!w_last) begin
            r_x <= r_xmin;
            r_y <= r_y + 16'd1;
          end else begin
            r_tri_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule
